// File: rtl/ui_pkg.sv
// Shared types and constants for the operator input panel.
package ui_pkg;

  // Width of one staged byte (switch value and UART payload).
  localparam int unsigned DATA_W = 8;

  typedef logic [DATA_W-1:0] byte_t;

  // IDLE: nothing offered to the UART. SEND: FIFO head offered with valid high.
  typedef enum logic {
    IDLE,
    SEND
  } panel_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, level debounce, rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic press_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic            sync1_q;
  logic            sync2_q;
  logic            stable_q, stable_d;
  logic            prev_q;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count how long the synced level has disagreed with the accepted level; any agreement
  // (a bounce back) restarts the count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CntOne;
    end
    // Only the 0->1 transition of the accepted level is a press; release is silent.
    press_d = stable_q & ~prev_q;
  end

  // Synchroniser, debounce state and registered press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/uart_input_panel.sv
// Operator input front-end: debounced LOAD/SEND buttons, switch-byte FIFO, and a
// valid/ready drain of the FIFO toward the UART transmitter.
module uart_input_panel
  import ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_W-1:0]                 sw_i,
  input  logic                              btn_load_i,
  input  logic                              btn_send_i,
  output logic [DATA_W-1:0]                 tx_data_o,
  output logic                              tx_valid_o,
  input  logic                              tx_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [DATA_W-1:0]                 last_byte_o,
  output logic                              overflow_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  logic load_press;
  logic send_press;

  byte_t           mem_q [FIFO_DEPTH];
  byte_t           mem_d [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] rd_ptr_nxt;
  logic [CntW-1:0] count_q, count_d;
  panel_state_t    state_q, state_d;
  byte_t           tx_data_q, tx_data_d;
  byte_t           last_byte_q, last_byte_d;
  logic            overflow_q, overflow_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load_db (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (btn_load_i),
    .press_o(load_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_send_db (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (btn_send_i),
    .press_o(send_press)
  );

  // FIFO datapath: push/pop decisions, pointers, occupancy, display byte, overflow pulse.
  always_comb begin
    full  = (count_q == CntFull);
    empty = (count_q == '0);
    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    push  = load_press && !full;
    pop   = (state_q == SEND) && tx_ready_i;

    rd_ptr_nxt = rd_ptr_q + PtrOne;

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = sw_i;
    end

    wr_ptr_d    = push ? (wr_ptr_q + PtrOne) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_nxt : rd_ptr_q;
    count_d     = count_q + (push ? CntOne : '0) - (pop ? CntOne : '0);
    last_byte_d = push ? sw_i : last_byte_q;
    overflow_d  = load_press && full;
  end

  // Transmit FSM and registered head-of-FIFO presented to the UART.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: begin
        if (send_press && !empty) begin
          state_d   = SEND;
          tx_data_d = mem_q[rd_ptr_q];
        end
      end
      SEND: begin
        // Data only moves on a handshake, so it is stable under backpressure.
        if (tx_ready_i) begin
          if (count_q != CntOne) begin
            tx_data_d = mem_q[rd_ptr_nxt];
          end else if (push) begin
            // Last entry leaves as a new one arrives: the new byte is not in mem_q yet.
            tx_data_d = sw_i;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      tx_data_q   <= '0;
      last_byte_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      last_byte_q <= last_byte_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage array; contents are meaningless until written, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tx_valid_o   = (state_q == SEND);
  assign tx_data_o    = tx_data_q;
  assign fifo_count_o = count_q;
  assign full_o       = full;
  assign empty_o      = empty;
  assign last_byte_o  = last_byte_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_uart_input_panel.sv
// Directed bench for uart_input_panel with a byte scoreboard on the TX handshake.
module tb_uart_input_panel;
  import ui_pkg::*;

  localparam int unsigned DbCycles = 4;
  localparam int unsigned Depth    = 4;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] sw_i;
  logic              btn_load_i;
  logic              btn_send_i;
  logic [DATA_W-1:0] tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic [2:0]        fifo_count_o;
  logic              full_o;
  logic              empty_o;
  logic [DATA_W-1:0] last_byte_o;
  logic              overflow_o;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] mon_exp;

  uart_input_panel #(
    .DEBOUNCE_CYCLES(DbCycles),
    .FIFO_DEPTH     (Depth)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_i        (sw_i),
    .btn_load_i  (btn_load_i),
    .btn_send_i  (btn_send_i),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .fifo_count_o(fifo_count_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .last_byte_o (last_byte_o),
    .overflow_o  (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every offered byte must be the oldest expected one; a handshake retires it.
  always @(negedge clk) begin
    if (!rst && tx_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL tx_unexpected observed=%0h expected=none", tx_data_o);
      end else begin
        mon_exp = exp_q[0];
        total++;
        assert (tx_data_o === mon_exp)
        else begin
          bad++;
          $error("FAIL tx_data observed=%0h expected=%0h", tx_data_o, mon_exp);
        end
        if (tx_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  // Press LOAD with switch value b; the push lands on the 8th edge after the raw edge.
  task automatic load_byte(input logic [7:0] b, input bit ok, input int cnt_after);
    sw_i       = b;
    btn_load_i = 1'b1;
    repeat (7) step();
    chk("pre_push_count", fifo_count_o, cnt_after - (ok ? 1 : 0));
    chk("pre_push_ovf", overflow_o, 0);
    if (ok) exp_q.push_back(b);
    step();
    chk("push_count", fifo_count_o, cnt_after);
    chk("overflow_pulse", overflow_o, !ok);
    if (ok) chk("last_byte", last_byte_o, b);
    step();
    chk("overflow_clear", overflow_o, 0);
    btn_load_i = 1'b0;
    repeat (8) step();
    chk("no_release_push", fifo_count_o, cnt_after);
  endtask

  // Raise SEND and advance to the first cycle the FSM can be in SEND.
  task automatic send_raise();
    btn_send_i = 1'b1;
    repeat (8) step();
  endtask

  task automatic send_release();
    btn_send_i = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    rst        = 1'b1;
    sw_i       = '0;
    btn_load_i = 1'b0;
    btn_send_i = 1'b0;
    tx_ready_i = 1'b0;
    repeat (3) step();
    chk("rst_valid", tx_valid_o, 0);
    chk("rst_data", tx_data_o, 0);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_last", last_byte_o, 0);
    chk("rst_ovf", overflow_o, 0);
    rst = 1'b0;
    step();

    // 1. Bouncing LOAD then a steady hold: exactly one push.
    sw_i = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      btn_load_i = ((i / 2) % 2) == 0;
      step();
    end
    chk("bounce_no_push", fifo_count_o, 0);
    btn_load_i = 1'b1;
    exp_q.push_back(8'h3C);
    repeat (12) step();
    chk("bounce_count", fifo_count_o, 1);
    chk("bounce_last", last_byte_o, 8'h3C);
    btn_load_i = 1'b0;
    repeat (8) step();
    chk("bounce_single", fifo_count_o, 1);
    tx_ready_i = 1'b1;
    send_raise();
    send_release();
    chk("t1_drained", empty_o, 1);

    // 2. Three bytes drained back-to-back.
    load_byte(8'h11, 1'b1, 1);
    load_byte(8'h22, 1'b1, 2);
    load_byte(8'h33, 1'b1, 3);
    send_raise();
    for (int i = 0; i < 3; i++) begin
      chk("t2_valid_run", tx_valid_o, 1);
      step();
    end
    chk("t2_valid_end", tx_valid_o, 0);
    chk("t2_empty", empty_o, 1);
    send_release();

    // 3. Backpressure holds the head.
    tx_ready_i = 1'b0;
    load_byte(8'h11, 1'b1, 1);
    load_byte(8'h22, 1'b1, 2);
    load_byte(8'h33, 1'b1, 3);
    send_raise();
    chk("t3_valid", tx_valid_o, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", tx_valid_o, 1);
      chk("t3_hold_data", tx_data_o, 8'h11);
    end
    tx_ready_i = 1'b1;
    repeat (3) step();
    chk("t3_valid_end", tx_valid_o, 0);
    chk("t3_empty", empty_o, 1);
    send_release();

    // 4. Overflow on the fifth LOAD.
    tx_ready_i = 1'b0;
    load_byte(8'hA0, 1'b1, 1);
    load_byte(8'hA1, 1'b1, 2);
    load_byte(8'hA2, 1'b1, 3);
    load_byte(8'hA3, 1'b1, 4);
    chk("t4_full", full_o, 1);
    load_byte(8'hA4, 1'b0, 4);
    chk("t4_full_after", full_o, 1);
    chk("t4_last_kept", last_byte_o, 8'hA3);
    tx_ready_i = 1'b1;
    send_raise();
    repeat (4) step();
    chk("t4_valid_end", tx_valid_o, 0);
    chk("t4_empty", empty_o, 1);
    send_release();

    // 5a. SEND while empty is ignored.
    send_raise();
    chk("t5_empty_send", tx_valid_o, 0);
    step();
    chk("t5_empty_send2", tx_valid_o, 0);
    send_release();
    chk("t5_empty_send3", tx_valid_o, 0);

    // 5b. Push coincides with the pop of the last entry.
    tx_ready_i = 1'b0;
    load_byte(8'h5A, 1'b1, 1);
    send_raise();
    chk("t5_in_send", tx_valid_o, 1);
    btn_send_i = 1'b0;
    sw_i       = 8'h6B;
    btn_load_i = 1'b1;
    exp_q.push_back(8'h6B);
    repeat (7) step();
    tx_ready_i = 1'b1;
    step();
    tx_ready_i = 1'b0;
    chk("t5_count", fifo_count_o, 1);
    chk("t5_stay_send", tx_valid_o, 1);
    chk("t5_next_data", tx_data_o, 8'h6B);
    chk("t5_last", last_byte_o, 8'h6B);
    btn_load_i = 1'b0;
    tx_ready_i = 1'b1;
    step();
    chk("t5_valid_end", tx_valid_o, 0);
    chk("t5_empty", empty_o, 1);
    repeat (8) step();

    // 6. Reset after the first handshake of a burst.
    tx_ready_i = 1'b0;
    load_byte(8'h01, 1'b1, 1);
    load_byte(8'h02, 1'b1, 2);
    load_byte(8'h03, 1'b1, 3);
    send_raise();
    chk("t6_valid", tx_valid_o, 1);
    tx_ready_i = 1'b1;
    step();
    chk("t6_after_hs", tx_data_o, 8'h02);
    rst        = 1'b1;
    tx_ready_i = 1'b0;
    step();
    chk("t6_valid", tx_valid_o, 0);
    chk("t6_count", fifo_count_o, 0);
    chk("t6_empty", empty_o, 1);
    chk("t6_last", last_byte_o, 0);
    chk("t6_data", tx_data_o, 0);
    exp_q.delete();
    rst        = 1'b0;
    btn_send_i = 1'b0;
    repeat (10) step();
    chk("t6_idle", tx_valid_o, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
